// File: rtl/mem_bus_arbiter.sv
// Two-way arbiter sharing the memory bus between I-cache and D-cache; grant held for a whole burst.
// Define ARB_RR_EN for round-robin tie breaking; otherwise D wins every tie.
module mem_bus_arbiter #(
    parameter int BUS_DATA_WIDTH = 64,
    parameter int BUS_TAG_WIDTH  = 13,
    parameter int BURST_BEATS    = 8
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      i_reqcyc,
    input  logic [BUS_DATA_WIDTH-1:0] i_req,
    input  logic [BUS_TAG_WIDTH-1:0]  i_reqtag,
    output logic                      i_reqack,
    output logic                      i_respcyc,
    output logic [BUS_DATA_WIDTH-1:0] i_resp,
    output logic [BUS_TAG_WIDTH-1:0]  i_resptag,
    input  logic                      i_respack,
    input  logic                      d_reqcyc,
    input  logic [BUS_DATA_WIDTH-1:0] d_req,
    input  logic [BUS_TAG_WIDTH-1:0]  d_reqtag,
    output logic                      d_reqack,
    output logic                      d_respcyc,
    output logic [BUS_DATA_WIDTH-1:0] d_resp,
    output logic [BUS_TAG_WIDTH-1:0]  d_resptag,
    input  logic                      d_respack,
    output logic                      bus_reqcyc,
    output logic [BUS_DATA_WIDTH-1:0] bus_req,
    output logic [BUS_TAG_WIDTH-1:0]  bus_reqtag,
    input  logic                      bus_reqack,
    input  logic                      bus_respcyc,
    input  logic [BUS_DATA_WIDTH-1:0] bus_resp,
    input  logic [BUS_TAG_WIDTH-1:0]  bus_resptag,
    output logic                      bus_respack,
    output logic [1:0]                owner
);

    localparam int CW = $clog2(BURST_BEATS + 1);
    localparam logic [CW-1:0] LAST = CW'(BURST_BEATS - 1);
    localparam logic [1:0] OWN_NONE = 2'b00;
    localparam logic [1:0] OWN_I    = 2'b01;
    localparam logic [1:0] OWN_D    = 2'b10;

    typedef enum logic [1:0] {IDLE, ADDR, WDATA, RESP} state_t;

    state_t          state;
    logic [CW-1:0]   cnt;
`ifdef ARB_RR_EN
    logic            last_owner;  // 0 = I, 1 = D
`endif

    logic                      own_reqcyc;
    logic [BUS_DATA_WIDTH-1:0] own_req;
    logic [BUS_TAG_WIDTH-1:0]  own_reqtag;
    logic                      own_respack;
    logic                      pick_d;

    always_comb begin
        own_reqcyc  = 1'b0;
        own_req     = '0;
        own_reqtag  = '0;
        own_respack = 1'b0;
        case (owner)
            OWN_I: begin
                own_reqcyc  = i_reqcyc;
                own_req     = i_req;
                own_reqtag  = i_reqtag;
                own_respack = i_respack;
            end
            OWN_D: begin
                own_reqcyc  = d_reqcyc;
                own_req     = d_req;
                own_reqtag  = d_reqtag;
                own_respack = d_respack;
            end
            default: ;
        endcase
    end

    always_comb begin
`ifdef ARB_RR_EN
        pick_d = d_reqcyc && (!i_reqcyc || !last_owner);
`else
        pick_d = d_reqcyc;
`endif
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
            owner <= OWN_NONE;
            cnt   <= '0;
`ifdef ARB_RR_EN
            last_owner <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: if (i_reqcyc || d_reqcyc) begin
                    state <= ADDR;
                    owner <= pick_d ? OWN_D : OWN_I;
                    cnt   <= '0;
`ifdef ARB_RR_EN
                    // only contested grants move the pointer, so back-to-back ties alternate
                    if (i_reqcyc && d_reqcyc)
                        last_owner <= pick_d;
`endif
                end
                ADDR: begin
                    if (!own_reqcyc) begin
                        state <= IDLE;
                        owner <= OWN_NONE;
                    end else if (bus_reqack) begin
                        state <= own_reqtag[BUS_TAG_WIDTH-1] ? WDATA : RESP;
                        cnt   <= '0;
                    end
                end
                WDATA: if (own_reqcyc && bus_reqack) begin
                    if (cnt == LAST) begin
                        state <= IDLE;
                        owner <= OWN_NONE;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                RESP: if (bus_respcyc && own_respack) begin
                    if (cnt == LAST) begin
                        state <= IDLE;
                        owner <= OWN_NONE;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                    owner <= OWN_NONE;
                end
            endcase
        end
    end

    // Datapath steering; everything not routed to the current owner stays at 0.
    always_comb begin
        bus_reqcyc  = 1'b0;
        bus_req     = '0;
        bus_reqtag  = '0;
        bus_respack = 1'b0;
        i_reqack    = 1'b0;
        i_respcyc   = 1'b0;
        i_resp      = '0;
        i_resptag   = '0;
        d_reqack    = 1'b0;
        d_respcyc   = 1'b0;
        d_resp      = '0;
        d_resptag   = '0;
        case (state)
            ADDR, WDATA: begin
                bus_reqcyc = own_reqcyc;
                bus_req    = own_req;
                bus_reqtag = own_reqtag;
                if (owner == OWN_I) i_reqack = bus_reqack;
                if (owner == OWN_D) d_reqack = bus_reqack;
            end
            RESP: begin
                bus_respack = own_respack;
                if (owner == OWN_I) begin
                    i_respcyc = bus_respcyc;
                    i_resp    = bus_resp;
                    i_resptag = bus_resptag;
                end
                if (owner == OWN_D) begin
                    d_respcyc = bus_respcyc;
                    d_resp    = bus_resp;
                    d_resptag = bus_resptag;
                end
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed bench for mem_bus_arbiter: requester and bus-slave models in one process, scoreboard queues.
module tb_mem_bus_arbiter;
    localparam int DW = 64;
    localparam int TW = 13;
    localparam int NB = 8;

    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    logic i_reqcyc, i_reqack, i_respcyc, i_respack;
    logic d_reqcyc, d_reqack, d_respcyc, d_respack;
    logic [DW-1:0] i_req, i_resp, d_req, d_resp;
    logic [TW-1:0] i_reqtag, i_resptag, d_reqtag, d_resptag;
    logic bus_reqcyc, bus_reqack, bus_respcyc, bus_respack;
    logic [DW-1:0] bus_req, bus_resp;
    logic [TW-1:0] bus_reqtag, bus_resptag;
    logic [1:0] owner;

    mem_bus_arbiter #(.BUS_DATA_WIDTH(DW), .BUS_TAG_WIDTH(TW), .BURST_BEATS(NB)) dut (
        .clk(clk), .reset(reset),
        .i_reqcyc(i_reqcyc), .i_req(i_req), .i_reqtag(i_reqtag), .i_reqack(i_reqack),
        .i_respcyc(i_respcyc), .i_resp(i_resp), .i_resptag(i_resptag), .i_respack(i_respack),
        .d_reqcyc(d_reqcyc), .d_req(d_req), .d_reqtag(d_reqtag), .d_reqack(d_reqack),
        .d_respcyc(d_respcyc), .d_resp(d_resp), .d_resptag(d_resptag), .d_respack(d_respack),
        .bus_reqcyc(bus_reqcyc), .bus_req(bus_req), .bus_reqtag(bus_reqtag), .bus_reqack(bus_reqack),
        .bus_respcyc(bus_respcyc), .bus_resp(bus_resp), .bus_resptag(bus_resptag),
        .bus_respack(bus_respack), .owner(owner)
    );

    typedef struct {
        logic [31:0]   addr;
        logic [TW-1:0] tag;
        int            abort;  // cycles in address phase before giving up, 0 = never
    } txn_t;

    txn_t iq[$], dq[$];
    logic [DW-1:0] i_exp[$], d_exp[$], w_exp[$];
    logic [TW-1:0] exp_tag[2];

    int n_tests = 0, n_fail = 0, cyc = 0;
    int rs[2], age[2], wb[2], start_cyc[2], drop_cyc[2], rcv[2], ahs_cnt[2], last_cyc[2];
    txn_t cur[2];
    logic ahs[2];
    logic [1:0] rcyc, rack;
    logic [DW-1:0] rdat[2];
    logic [TW-1:0] rtag[2];
    int stall_side = -1, stall_at = 0, stall_left = 0, stall_cyc = 0;
    int sp = 0, sbeat = 0, swait = 0, ack_delay = 0, bus_hs = 0;
    logic [31:0] s_addr;
    logic [TW-1:0] s_tag;
    logic [1:0] prev_owner;
    int glog[$], gcyc[$];
    logic bus_req_at_grant;

    function automatic logic [DW-1:0] dfn(input logic [31:0] a, input int k);
        return {a, 32'(k)} ^ 64'h5a5a_0000_0000_a5a5;
    endfunction

    function automatic logic [DW-1:0] wfn(input logic [31:0] a, input int k);
        return dfn(a, k) ^ 64'h0000_ffff_ffff_0000;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drive_req();
        txn_t t;
        logic got;
        for (int s = 0; s < 2; s++) begin
            case (rs[s])
                0: begin
                    got = 1'b0;
                    if (s == 0 && iq.size() > 0) begin t = iq.pop_front(); got = 1'b1; end
                    if (s == 1 && dq.size() > 0) begin t = dq.pop_front(); got = 1'b1; end
                    if (got) begin
                        cur[s] = t; rcyc[s] = 1'b1; rdat[s] = {32'h0, t.addr}; rtag[s] = t.tag;
                        rs[s] = 1; age[s] = 0; start_cyc[s] = cyc;
                    end
                end
                1: if (ahs[s]) begin
                    if (cur[s].tag[TW-1]) begin rs[s] = 2; wb[s] = 0; rdat[s] = wfn(cur[s].addr, 0); end
                    else begin rcyc[s] = 1'b0; rs[s] = 0; end
                end else begin
                    if (cur[s].abort > 0 && age[s] == cur[s].abort) begin
                        rcyc[s] = 1'b0; rs[s] = 0; drop_cyc[s] = cyc;
                    end
                    age[s]++;
                end
                default: if (ahs[s]) begin
                    wb[s]++;
                    if (wb[s] == NB) begin rcyc[s] = 1'b0; rs[s] = 0; end
                    else rdat[s] = wfn(cur[s].addr, wb[s]);
                end
            endcase
            rack[s] = 1'b1;
            if (stall_side == s && rcv[s] == stall_at && stall_left > 0) begin
                rack[s] = 1'b0; stall_left--;
            end
        end
        i_reqcyc = rcyc[0]; i_req = rdat[0]; i_reqtag = rtag[0]; i_respack = rack[0];
        d_reqcyc = rcyc[1]; d_req = rdat[1]; d_reqtag = rtag[1]; d_respack = rack[1];
    endtask

    task automatic drive_slave();
        case (sp)
            0: begin bus_reqack = bus_reqcyc && (swait >= ack_delay); bus_respcyc = 1'b0; end
            1: begin bus_reqack = bus_reqcyc; bus_respcyc = 1'b0; end
            default: begin
                bus_reqack = 1'b0; bus_respcyc = 1'b1;
                bus_resp = dfn(s_addr, sbeat); bus_resptag = s_tag;
            end
        endcase
    endtask

    task automatic sample();
        logic rh, ph;
        rh = bus_reqcyc && bus_reqack;
        ph = bus_respcyc && bus_respack;
        ahs[0] = i_reqcyc && i_reqack;
        ahs[1] = d_reqcyc && d_reqack;
        for (int s = 0; s < 2; s++) begin
            if (ahs[s]) ahs_cnt[s]++;
            if (ahs[s] && rs[s] == 1) begin
                exp_tag[s] = cur[s].tag;
                for (int k = 0; k < NB; k++) begin
                    if (cur[s].tag[TW-1]) w_exp.push_back(wfn(cur[s].addr, k));
                    else if (s == 0) i_exp.push_back(dfn(cur[s].addr, k));
                    else d_exp.push_back(dfn(cur[s].addr, k));
                end
            end
        end
        case (sp)
            0: if (rh) begin
                s_addr = bus_req[31:0]; s_tag = bus_reqtag;
                sp = bus_reqtag[TW-1] ? 1 : 2; sbeat = 0; swait = 0; bus_hs++;
            end else if (bus_reqcyc) swait++;
            else swait = 0;
            1: if (rh) begin
                bus_hs++;
                if (w_exp.size() == 0) chk("wdata_extra", 1, 0);
                else chk("wdata", bus_req, w_exp.pop_front());
                sbeat++;
                if (sbeat == NB) sp = 0;
            end
            default: if (ph) begin
                sbeat++;
                if (sbeat == NB) sp = 0;
            end
        endcase
        if (i_respcyc && i_respack) begin
            rcv[0]++; last_cyc[0] = cyc;
            if (i_exp.size() == 0) chk("i_resp_extra", 1, 0);
            else chk("i_resp", i_resp, i_exp.pop_front());
            chk("i_resptag", i_resptag, exp_tag[0]);
        end
        if (d_respcyc && d_respack) begin
            rcv[1]++; last_cyc[1] = cyc;
            if (d_exp.size() == 0) chk("d_resp_extra", 1, 0);
            else chk("d_resp", d_resp, d_exp.pop_front());
            chk("d_resptag", d_resptag, exp_tag[1]);
        end
        chk("i_only_when_owner", 64'((i_respcyc || i_reqack) && owner != 2'b01), 0);
        chk("d_only_when_owner", 64'((d_respcyc || d_reqack) && owner != 2'b10), 0);
        if (owner == 2'b01 && bus_respcyc) begin
            chk("respack_pass", bus_respack, i_respack);
            if (!bus_respack) stall_cyc++;
        end
        if (owner != prev_owner && owner != 2'b00) begin
            glog.push_back(int'(owner)); gcyc.push_back(cyc); bus_req_at_grant = bus_reqcyc;
        end
        prev_owner = owner;
    endtask

    task automatic tick();
        cyc++;
        @(posedge clk);
        #1 drive_req();
        #1 drive_slave();
        @(negedge clk);
        sample();
    endtask

    task automatic bfm_reset();
        for (int s = 0; s < 2; s++) begin
            rs[s] = 0; age[s] = 0; wb[s] = 0; ahs[s] = 1'b0; rdat[s] = '0; rtag[s] = '0;
        end
        rcyc = '0; rack = '0;
        i_reqcyc = 0; i_req = '0; i_reqtag = '0; i_respack = 0;
        d_reqcyc = 0; d_req = '0; d_reqtag = '0; d_respack = 0;
        bus_reqack = 0; bus_respcyc = 0; bus_resp = '0; bus_resptag = '0;
        sp = 0; sbeat = 0; swait = 0; stall_left = 0; stall_side = -1;
        iq.delete(); dq.delete(); i_exp.delete(); d_exp.delete(); w_exp.delete();
    endtask

    task automatic clear_stats();
        for (int s = 0; s < 2; s++) begin rcv[s] = 0; ahs_cnt[s] = 0; last_cyc[s] = 0; end
        bus_hs = 0; stall_cyc = 0; glog.delete(); gcyc.delete();
    endtask

    task automatic wait_idle(input int max);
        int n;
        logic done;
        n = 0;
        do begin
            tick(); n++;
            done = iq.size() == 0 && dq.size() == 0 && rs[0] == 0 && rs[1] == 0 &&
                   sp == 0 && owner == 2'b00 && rcyc == 2'b00;
        end while (!done && n < max);
        chk("idle_timeout", 64'(done), 1);
    endtask

    task automatic tie_pair(input string tag, input int first);
        clear_stats();
        iq.push_back('{32'h3000, 13'h0001, 0});
        dq.push_back('{32'h4000, 13'h0002, 0});
        wait_idle(300);
        chk({tag, "_grants"}, glog.size(), 2);
        if (glog.size() == 2) begin
            chk({tag, "_first"}, glog[0], first);
            chk({tag, "_second"}, glog[1], 3 - first);
            // finishing edge, one IDLE cycle, then the waiting side shows as owner
            chk({tag, "_gap"}, gcyc[1] - last_cyc[glog[0] - 1], 2);
        end
        chk({tag, "_i_beats"}, rcv[0], NB);
        chk({tag, "_d_beats"}, rcv[1], NB);
    endtask

    initial begin
        int n;
        bfm_reset(); clear_stats(); prev_owner = 2'b00;

        reset = 1'b0;
        repeat (3) tick();
        chk("rst_owner", owner, 0);
        chk("rst_outputs", {bus_reqcyc, bus_respack, i_reqack, i_respcyc, d_reqack, d_respcyc}, 0);
        reset = 1'b1;
        tick();

        // I read, slave acks the address two cycles late
        clear_stats(); ack_delay = 2;
        iq.push_back('{32'h1000, 13'h0040, 0});
        wait_idle(200);
        chk("t1_grants", glog.size(), 1);
        if (gcyc.size() > 0) chk("t1_grant_latency", gcyc[0] - start_cyc[0], 1);
        chk("t1_bus_reqcyc_at_grant", bus_req_at_grant, 1);
        chk("t1_i_reqack_count", ahs_cnt[0], 1);
        chk("t1_bus_handshakes", bus_hs, 1);
        chk("t1_i_beats", rcv[0], NB);
        chk("t1_d_beats", rcv[1], 0);
        chk("t1_owner_end", owner, 0);

        // simultaneous reads, twice
        ack_delay = 0;
        tie_pair("t2a", 2);
`ifdef ARB_RR_EN
        tie_pair("t2b", 1);
`else
        tie_pair("t2b", 2);
`endif

        // D write burst
        clear_stats();
        dq.push_back('{32'h2000, 13'h1040, 0});
        wait_idle(200);
        chk("t3_bus_handshakes", bus_hs, NB + 1);
        chk("t3_d_reqacks", ahs_cnt[1], NB + 1);
        chk("t3_wdata_left", w_exp.size(), 0);
        chk("t3_no_resp", rcv[0] + rcv[1], 0);
        chk("t3_owner_end", owner, 0);

        // I abandons its address beat while D waits
        clear_stats(); ack_delay = 3;
        iq.push_back('{32'h5000, 13'h0005, 1});
        tick(); tick();
        dq.push_back('{32'h6000, 13'h0006, 0});
        wait_idle(200);
        chk("t4_grants", glog.size(), 2);
        if (glog.size() == 2) begin
            chk("t4_order", {glog[0][1:0], glog[1][1:0]}, 4'b0110);
            chk("t4_d_after_drop", gcyc[1] - drop_cyc[0], 2);
        end
        chk("t4_i_acks", ahs_cnt[0], 0);
        chk("t4_d_beats", rcv[1], NB);
        chk("t4_bus_handshakes", bus_hs, 1);

        // reset in the middle of a read response
        clear_stats(); ack_delay = 0;
        iq.push_back('{32'h7000, 13'h0007, 0});
        n = 0;
        while (rcv[0] < 4 && n < 100) begin tick(); n++; end
        chk("t5_reached_beat4", rcv[0], 4);
        chk("t5_owner_before", owner, 1);
        reset = 1'b0;
        #1;
        chk("t5_owner_reset", owner, 0);
        chk("t5_outputs_reset", {bus_reqcyc, bus_respack, i_reqack, i_respcyc, d_reqack, d_respcyc}, 0);
        chk("t5_i_resp_reset", i_resp, 0);
        bfm_reset();
        repeat (2) tick();
        reset = 1'b1;
        clear_stats();
        iq.push_back('{32'h7100, 13'h0017, 0});
        wait_idle(200);
        chk("t5_beats_after", rcv[0], NB);
        chk("t5_exp_left", i_exp.size(), 0);

        // requester withholds respack for three cycles at beat 5
        clear_stats();
        stall_side = 0; stall_at = 4; stall_left = 3;
        iq.push_back('{32'h8000, 13'h0008, 0});
        wait_idle(200);
        chk("t6_beats", rcv[0], NB);
        chk("t6_exp_left", i_exp.size(), 0);
        chk("t6_stall_cycles", stall_cyc, 3);
        stall_side = -1;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
